// File: rtl/conv_pkg.sv
// Shared constants and helpers for the 3x3 convolution pipeline.
// The window generator and the convolution stage both import this package.
package conv_pkg;

    localparam int PIXEL_W    = 8;
    localparam int KERNEL_DIM = 3;
    localparam int WINDOW_W   = PIXEL_W * KERNEL_DIM * KERNEL_DIM;

    typedef logic [PIXEL_W-1:0]  pixel_t;
    typedef logic [WINDOW_W-1:0] window_t;

    // Bit offset of window element (r,c); r=0 is the oldest line, c=0 the oldest column.
    function automatic int byte_offset(input int r, input int c);
        return (r * KERNEL_DIM + c) * PIXEL_W;
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream in / 3x3 window out bundle between the producer and the convolution stage.
// The stream has no backpressure, so there is no ready signal in either direction.
interface conv_window_gen_if;

    logic [conv_pkg::PIXEL_W-1:0]  i_pixel_data;
    logic                          i_pixel_data_valid;
    logic                          i_sof;
    logic [conv_pkg::WINDOW_W-1:0] o_pixel_data;
    logic                          o_pixel_data_valid;
    logic                          o_frame_done;

    modport slave (
        input  i_pixel_data, i_pixel_data_valid, i_sof,
        output o_pixel_data, o_pixel_data_valid, o_frame_done
    );

    modport master (
        output i_pixel_data, i_pixel_data_valid, i_sof,
        input  o_pixel_data, o_pixel_data_valid, o_frame_done
    );

endinterface

// File: rtl/conv_line_buffer.sv
// Line buffer RAM: combinational read, synchronous write, so a read and a write
// to the same address in one cycle return the old contents.
module conv_line_buffer #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Contents are deliberately not reset; the window generator masks stale lines.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two buffered lines plus a 3x3 shift window,
// emitting only windows that lie completely inside the frame.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    conv_window_gen_if.slave  bus
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(KERNEL_DIM - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(KERNEL_DIM - 1);

    logic [COL_W-1:0]     col, col_used;
    logic [ROW_W-1:0]     row, row_used;
    logic                 accept;
    logic [2*PIXEL_W-1:0] lb_rdata, lb_wdata;
    pixel_t               win [KERNEL_DIM][KERNEL_DIM];
    window_t              win_flat;
    logic                 win_valid, frame_done;

    assign accept   = bus.i_pixel_data_valid;
    assign col_used = bus.i_sof ? '0 : col;
    assign row_used = bus.i_sof ? '0 : row;

    // Upper byte holds line row-2, lower byte line row-1; both lines age by one on each write.
    assign lb_wdata = {lb_rdata[PIXEL_W-1:0], bus.i_pixel_data};

    conv_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (2 * PIXEL_W),
        .ADDR_W (COL_W)
    ) u_line_buffer (
        .i_clk (i_clk),
        .we    (accept),
        .addr  (col_used),
        .wdata (lb_wdata),
        .rdata (lb_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_used == COL_LAST) begin
                col <= '0;
                row <= (row_used == ROW_LAST) ? '0 : row_used + ROW_W'(1);
            end else begin
                col <= col_used + COL_W'(1);
                row <= row_used;
            end
        end
    end

    // Stale columns from the previous line are fully shifted out by column 2, which is
    // the first column allowed to raise a window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < KERNEL_DIM; r++) begin
                for (int c = 0; c < KERNEL_DIM; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < KERNEL_DIM; r++) begin
                for (int c = 0; c < KERNEL_DIM - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
            end
            win[0][KERNEL_DIM-1] <= lb_rdata[2*PIXEL_W-1:PIXEL_W];
            win[1][KERNEL_DIM-1] <= lb_rdata[PIXEL_W-1:0];
            win[2][KERNEL_DIM-1] <= bus.i_pixel_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= accept && (col_used >= COL_MIN) && (row_used >= ROW_MIN);
            frame_done <= accept && (col_used == COL_LAST) && (row_used == ROW_LAST);
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < KERNEL_DIM; r++) begin
            for (int c = 0; c < KERNEL_DIM; c++) begin
                win_flat[byte_offset(r, c) +: PIXEL_W] = win[r][c];
            end
        end
    end

    assign bus.o_pixel_data       = win_flat;
    assign bus.o_pixel_data_valid = win_valid;
    assign bus.o_frame_done       = frame_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on a 4x4 frame: a frame-array model queues
// expected windows at issue time, and a negedge monitor pops them as the DUT emits.
module tb_conv_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    typedef struct {
        logic [71:0] win;
        logic        done;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    conv_window_gen_if bus ();

    conv_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          win_count;
    int          done_count;
    exp_t        exp_q [$];
    logic [71:0] seen [$];
    logic [7:0]  img [H][W];
    int          m_col = 0;
    int          m_row = 0;

    task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Window whose top-left pixel has value base in a raster 0..15-style frame.
    function automatic logic [71:0] win_of(input int base);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[(r*3+c)*8 +: 8] = 8'(base + r*W + c);
            end
        end
        return w;
    endfunction

    // Reference model: place the pixel in the frame image and, if a full 3x3 neighbourhood
    // ends here, queue it; then step the raster position.
    task automatic apply_stimulus(input logic [7:0] pix, input logic sof, input int gap);
        exp_t e;
        int   idx;
        if (sof) begin
            m_col = 0;
            m_row = 0;
        end
        img[m_row][m_col] = pix;
        if (m_col >= 2 && m_row >= 2) begin
            e.win = '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    e.win[(r*3+c)*8 +: 8] = img[m_row-2+r][m_col-2+c];
                end
            end
            e.done = (m_col == W-1) && (m_row == H-1);
            exp_q.push_back(e);
        end
        idx   = (m_row * W + m_col + 1) % (W * H);
        m_col = idx % W;
        m_row = idx / W;
        bus.i_pixel_data       = pix;
        bus.i_pixel_data_valid = 1'b1;
        bus.i_sof              = sof;
        @(posedge i_clk);
        #1;
        bus.i_pixel_data_valid = 1'b0;
        bus.i_sof              = 1'b0;
        bus.i_pixel_data       = $urandom_range(0, 255);
        repeat (gap) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_frame(input int base, input int first_sof, input int max_gap);
        for (int i = 0; i < W*H; i++) begin
            apply_stimulus(8'(base + i), (i == 0) && (first_sof != 0), $urandom_range(0, max_gap));
        end
    endtask

    task automatic begin_phase();
        win_count  = 0;
        done_count = 0;
        seen.delete();
    endtask

    task automatic end_phase(input string name, input int exp_wins, input int exp_dones);
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        check_output({name, " windows"}, 72'(win_count), 72'(exp_wins));
        check_output({name, " frame_done"}, 72'(done_count), 72'(exp_dones));
        check_output({name, " queue empty"}, 72'(exp_q.size()), 72'd0);
    endtask

    // Asserted between clock edges; outputs must clear without waiting for an edge.
    task automatic async_reset(input string name);
        #2;
        i_rst = 1'b1;
        #1;
        check_output({name, " data"}, bus.o_pixel_data, 72'd0);
        check_output({name, " valid"}, 72'(bus.o_pixel_data_valid), 72'd0);
        check_output({name, " done"}, 72'(bus.o_frame_done), 72'd0);
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // Monitor: every valid window must match the oldest queued expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst) begin
            if (bus.o_pixel_data_valid) begin
                win_count++;
                if (bus.o_frame_done) done_count++;
                seen.push_back(bus.o_pixel_data);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected window: got %h, expected no valid", bus.o_pixel_data);
                end else begin
                    e = exp_q.pop_front();
                    check_output("window data", bus.o_pixel_data, e.win);
                    check_output("window frame_done", 72'(bus.o_frame_done), 72'(e.done));
                end
            end else if (bus.o_frame_done) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL frame_done without valid: got 1, expected 0");
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.i_pixel_data       = '0;
        bus.i_pixel_data_valid = 1'b0;
        bus.i_sof              = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_output("reset data", bus.o_pixel_data, 72'd0);
        check_output("reset valid", 72'(bus.o_pixel_data_valid), 72'd0);
        check_output("reset done", 72'(bus.o_frame_done), 72'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        $display("[TB] basic back-to-back frame");
        begin_phase();
        send_frame(0, 1, 0);
        end_phase("basic", 4, 1);
        check_output("basic first window", seen[0], win_of(0));
        check_output("basic last window", seen[3], win_of(5));

        $display("[TB] gapped frame");
        begin_phase();
        for (int i = 0; i < W*H; i++) begin
            apply_stimulus(8'(i), i == 0, $urandom_range(1, 5));
        end
        end_phase("gapped", 4, 1);
        check_output("gapped first window", seen[0], win_of(0));
        check_output("gapped last window", seen[3], win_of(5));

        $display("[TB] mid-frame sof");
        begin_phase();
        for (int i = 0; i < 6; i++) apply_stimulus(8'(50 + i), i == 0, 0);
        send_frame(0, 1, 1);
        end_phase("midsof", 4, 1);
        check_output("midsof first window", seen[0], win_of(0));

        $display("[TB] async reset mid-frame");
        for (int i = 0; i <= 12; i++) apply_stimulus(8'(200 + i), i == 0, 0);
        async_reset("async reset");
        begin_phase();
        send_frame(0, 0, 0);
        end_phase("post reset", 4, 1);
        check_output("post reset first window", seen[0], win_of(0));

        $display("[TB] two frames back to back");
        begin_phase();
        send_frame(0, 1, 0);
        send_frame(100, 1, 0);
        end_phase("two frames", 8, 2);
        check_output("second frame first window", seen[4], win_of(100));
        check_output("second frame last window", seen[7], win_of(105));

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W*H-1) : W*H;
            for (int i = 0; i < len; i++) begin
                apply_stimulus(8'($urandom_range(0, 255)), i == 0, $urandom_range(0, 3));
            end
        end
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        check_output("random queue empty", 72'(exp_q.size()), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
